instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the Lab 4 processor. It owns the 6-bit program counter and the 64 × 12 instruction ROM (initialised from `Lab4.mif`), and hands one 12-bit instruction at a time to the decode/register-file stage over a valid/ready handshake. It implements run mode and single-step mode (SW1, advanced by KEY0), and accepts PC redirects from execute for jumps and branches.

## Interface
Parameters:
- `ADDR_W`, default 6: PC and ROM address width (64 words).
- `INSTR_W`, default 12: instruction width.
- `DEBOUNCE_CYCLES`, default 16: number of consecutive stable samples before a KEY0 level is accepted. The board build overrides it to about 1,000,000.
- `MEM_INIT`, default "Lab4.mif": ROM initialisation file.

Ports:
- `clk`  in  1: the single clock; all state is on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `step_mode`  in  1: SW1. 1 = single-step, 0 = free run.
- `step_key_n`  in  1: raw KEY0, active-low and asynchronous.
- `redirect_valid`  in  1: execute requests a PC change.
- `redirect_pc`  in  ADDR_W: new PC target.
- `instr_valid`  out  1: `instr` and `instr_pc` are valid.
- `instr`  out  INSTR_W: fetched instruction.
- `instr_pc`  out  ADDR_W: address the instruction was fetched from.
- `instr_ready`  in  1: decode accepts the instruction this cycle.
- `pc`  out  ADDR_W: current PC, for LED debug.

## Operation
ROM:
- Synchronous read, 1-cycle latency, addressed by `pc`.

FSM states are FETCH, LOAD, HOLD and GATE.
- **FETCH:** ROM address = `pc`. Always goes to LOAD.
- **LOAD:** register the ROM data into `instr` and `pc` into `instr_pc`. Set `instr_valid` = 1. Go to HOLD.
- **HOLD:** `instr_valid` = 1, and `instr`/`instr_pc` hold stable. When `instr_ready` = 1:
  - `pc` <= `pc` + 1, wrapping modulo 2^ADDR_W (63 → 0).
  - `instr_valid` <= 0.
  - Next state is GATE if `step_mode` = 1, otherwise FETCH.
- **GATE:** wait for `step_pulse`, then go to FETCH. Step pulses arriving in any other state are dropped, never queued.
- `step_mode` is sampled only on HOLD exit. Toggling it elsewhere has no effect until the next acceptance. Clearing it while in GATE makes GATE exit on the next cycle.

Redirect has priority over everything, in any state:
- `pc` <= `redirect_pc`, `instr_valid` <= 0, and any in-flight ROM read is discarded.
- Next state is GATE if `step_mode` = 1, otherwise FETCH.
- Redirect in the same cycle as a HOLD acceptance: the transfer completes (decode keeps the instruction) and `pc` takes `redirect_pc`, not `pc` + 1.

Step pulse generation:
- `step_key_n` passes through a 2-FF synchroniser, then the debouncer.
- The debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
- `step_pulse` is a 1-cycle pulse on the debounced 1 → 0 transition (press). Release generates nothing.

## Timing
- Reset values: `pc` = 0, state = FETCH, `instr_valid` = 0, `instr` = 0, `instr_pc` = 0, debounced level = 1, `step_pulse` = 0.
- After `rst` deasserts: FETCH in cycle 0, LOAD in cycle 1, `instr_valid` = 1 from cycle 2, carrying mem[0].
- Run mode with `instr_ready` tied to 1: one instruction every 3 cycles.
- Step mode: a `step_pulse` in cycle n while in GATE gives `instr_valid` = 1 in cycle n+3.
- KEY0 press to `step_pulse` = 2 synchroniser cycles + DEBOUNCE_CYCLES + 1.
- Redirect asserted in cycle n: `instr_valid` = 0 in cycle n+1. In run mode, the instruction at `redirect_pc` is valid in cycle n+3.
- All outputs are registered. There is no combinational path from `instr_ready` or `redirect_*` to any output.

## Structure
- `lab4_pkg` holds:
  - `INSTR_W`, `ADDR_W`, `NUM_REGS` = 8.
  - the `fetch_state_t` enum (FETCH, LOAD, HOLD, GATE).
  - `instr_t` = logic [INSTR_W-1:0].
- Sub-module `step_pulse` contains the synchroniser, debouncer and press-edge detector, with ports `clk`, `rst`, `key_n` and `pulse`.
- The ROM is inferred inside `instr_fetch` with the `ram_init_file` attribute set to `MEM_INIT`.

## Test plan
1. **Reset and run.** mem[0..2] = 12'h101, 12'h202, 12'h303; `step_mode` = 0; `instr_ready` = 1. Expect `instr_valid` pulses in cycles 2, 5 and 8, carrying 101/0, 202/1, 303/2 (`instr`/`instr_pc`).
2. **Backpressure.** `instr_ready` = 0 for 10 cycles after the first valid. Expect `instr` = 12'h101 held and `instr_pc` = 0 held; `pc` stays 0 until `instr_ready` rises.
3. **Single step.** `step_mode` = 1, DEBOUNCE_CYCLES = 4:
   - After mem[0] is accepted, there is no new valid for 50 cycles.
   - A 3-cycle KEY0 glitch produces no pulse.
   - A clean 20-cycle press produces exactly one new valid, carrying mem[1].
4. **Wrap-around.** `redirect_pc` = 62, then run. Expect `instr_pc` sequence 62, 63, 0, 1.
5. **Redirect during LOAD.** Redirect to 40 in the LOAD cycle for address 5. Expect the address-5 instruction never to be valid; the next valid has `instr_pc` = 40.
6. **Redirect coincident with acceptance.** Redirect to 10 on the HOLD/ready cycle at `instr_pc` = 3. Expect that transfer to complete, and the next `instr_pc` to be 10, not 4. Then assert `rst` mid-HOLD: all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lab4_pkg.sv
// Shared types and constants for the Lab 4 processor.
package lab4_pkg;

  localparam int unsigned INSTR_W  = 12;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned NUM_REGS = 8;

  typedef enum logic [1:0] {
    FETCH,
    LOAD,
    HOLD,
    GATE
  } fetch_state_t;

  typedef logic [INSTR_W-1:0] instr_t;

endpackage

// File: rtl/instr_fetch_step_pulse.sv
// KEY0 conditioning: 2-FF synchroniser, debouncer and press-edge detector.
module step_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pulse
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pulse_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      pulse   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse   <= pulse_d;
    end
  end

  // Any sample equal to the accepted level restarts the stability count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    pulse_d = level_q & ~level_d;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, instruction ROM and valid/ready handoff to decode,
// with free-run and single-step modes and execute-driven redirects.
module instr_fetch #(
  parameter int unsigned ADDR_W          = 6,
  parameter int unsigned INSTR_W         = 12,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter string       MEM_INIT        = "Lab4.mif"
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_mode,
  input  logic               step_key_n,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc
);

  import lab4_pkg::*;

  localparam int unsigned Depth = 1 << ADDR_W;

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] rom_q;
  logic               step_pulse_w;

  (* ram_init_file = MEM_INIT *) logic [INSTR_W-1:0] mem [Depth];

  // Unreset registered read so the ROM maps onto block memory.
  always_ff @(posedge clk) begin
    rom_q <= mem[pc_q];
  end

  step_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_pulse (
    .clk  (clk),
    .rst  (rst),
    .key_n(step_key_n),
    .pulse(step_pulse_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= '0;
      instr_pc_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;

    unique case (state_q)
      FETCH: state_d = LOAD;
      LOAD: begin
        instr_d    = rom_q;
        instr_pc_d = pc_q;
        valid_d    = 1'b1;
        state_d    = HOLD;
      end
      HOLD: begin
        if (instr_ready) begin
          pc_d    = pc_q + ADDR_W'(1);
          valid_d = 1'b0;
          state_d = step_mode ? GATE : FETCH;
        end
      end
      GATE: begin
        // Leaving step mode releases a parked fetch without a key press.
        if (step_pulse_w || !step_mode) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Redirect overrides everything; restarting at FETCH drops any ROM read.
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      state_d = step_mode ? GATE : FETCH;
    end
  end

  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: directed scenarios plus random traffic.
module tb_instr_fetch;

  localparam int AW    = 6;
  localparam int IW    = 12;
  localparam int DB    = 4;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          step_mode = 1'b0;
  logic          step_key_n = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          instr_ready = 1'b0;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic [AW-1:0] pc;

  int checks = 0;
  int errors = 0;
  int cyc;
  int exp_pc;

  logic [IW-1:0] tb_mem [DEPTH];
  int redir_q[$];
  int xfer_pc[$];
  int xfer_cyc[$];

  instr_fetch #(
    .ADDR_W         (AW),
    .INSTR_W        (IW),
    .DEBOUNCE_CYCLES(DB),
    .MEM_INIT       ("Lab4.mif")
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .step_mode     (step_mode),
    .step_key_n    (step_key_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .pc            (pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: each delivered instruction is the successor of the previous one,
  // except that after a redirect the next delivery comes from the target.
  always @(negedge clk) begin
    if (rst) begin
      exp_pc = 0;
    end else begin
      if (instr_valid && instr_ready) begin
        check("xfer_pc", 32'(instr_pc), 32'(exp_pc));
        check("xfer_instr", 32'(instr), 32'(tb_mem[exp_pc]));
        xfer_pc.push_back(int'(instr_pc));
        xfer_cyc.push_back(cyc);
        exp_pc = (exp_pc + 1) % DEPTH;
      end
      if (redirect_valid) begin
        if (redir_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL redir_queue: got empty, expected a target");
        end else begin
          exp_pc = redir_q.pop_front();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    tick();
    xfer_pc.delete();
    xfer_cyc.delete();
    redir_q.delete();
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_xfers(input int n, input int budget, input string name);
    int k = 0;
    while (xfer_pc.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++;
    if (xfer_pc.size() < n) begin
      errors++;
      $display("FAIL %s: timeout with %0d transfers, expected %0d", name, xfer_pc.size(), n);
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k = 0;
    while (!instr_valid && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(name, 32'(instr_valid), 32'd1);
  endtask

  task automatic redirect(input int target);
    redir_q.push_back(target);
    redirect_pc = AW'(target);
    redirect_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, base2;
    for (int i = 0; i < DEPTH; i++) tb_mem[i] = IW'($urandom);
    tb_mem[0] = 12'h101;
    tb_mem[1] = 12'h202;
    tb_mem[2] = 12'h303;
    #1;
    for (int i = 0; i < DEPTH; i++) dut.mem[i] = tb_mem[i];

    // Reset values and free run.
    #2;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    instr_ready = 1'b1;
    do_reset();
    wait_xfers(3, 30, "run_xfers");
    check("run_cyc0", 32'(xfer_cyc[0]), 32'd2);
    check("run_cyc1", 32'(xfer_cyc[1]), 32'd5);
    check("run_cyc2", 32'(xfer_cyc[2]), 32'd8);

    // Backpressure holds the instruction and the PC.
    instr_ready = 1'b0;
    do_reset();
    wait_valid(10, "bp_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("bp_instr", 32'(instr), 32'h101);
      check("bp_instr_pc", 32'(instr_pc), 32'd0);
      check("bp_pc", 32'(pc), 32'd0);
    end
    tick();
    instr_ready = 1'b1;
    wait_xfers(1, 5, "bp_release");
    @(negedge clk);
    #1;
    check("bp_pc_after", 32'(pc), 32'd1);

    // Single-step: park, reject a glitch, advance on a clean press.
    step_mode = 1'b1;
    instr_ready = 1'b1;
    do_reset();
    wait_xfers(1, 10, "step_first");
    repeat (50) tick();
    check("step_parked", 32'(xfer_pc.size()), 32'd1);
    step_key_n = 1'b0;
    repeat (3) tick();
    step_key_n = 1'b1;
    repeat (30) tick();
    check("step_glitch", 32'(xfer_pc.size()), 32'd1);
    step_key_n = 1'b0;
    repeat (20) tick();
    step_key_n = 1'b1;
    repeat (40) tick();
    check("step_press", 32'(xfer_pc.size()), 32'd2);
    check("step_pc", 32'(xfer_pc[1]), 32'd1);

    // Wrap-around after a redirect to 62, with redirect-to-valid latency.
    step_mode = 1'b0;
    repeat (3) tick();
    redirect(62);
    n = cyc;
    tick();
    redirect_valid = 1'b0;
    base = xfer_pc.size();
    wait_xfers(base + 4, 30, "wrap_xfers");
    check("wrap_pc0", 32'(xfer_pc[base]), 32'd62);
    check("wrap_pc1", 32'(xfer_pc[base + 1]), 32'd63);
    check("wrap_pc2", 32'(xfer_pc[base + 2]), 32'd0);
    check("wrap_pc3", 32'(xfer_pc[base + 3]), 32'd1);
    check("redir_latency", 32'(xfer_cyc[base]), 32'(n + 3));

    // Redirect during the LOAD cycle of address 5 drops that instruction.
    wait_xfers(base + 7, 20, "load_pre");
    check("load_pre_pc", 32'(xfer_pc[base + 6]), 32'd4);
    tick();
    tick();
    redirect(40);
    tick();
    redirect_valid = 1'b0;
    base2 = xfer_pc.size();
    wait_xfers(base2 + 1, 10, "load_redir");
    check("load_redir_pc", 32'(xfer_pc[base2]), 32'd40);

    // Redirect coincident with acceptance, then asynchronous reset in HOLD.
    tick();
    instr_ready = 1'b0;
    redirect(3);
    tick();
    redirect_valid = 1'b0;
    wait_valid(10, "coin_valid3");
    check("coin_at3", 32'(instr_pc), 32'd3);
    tick();
    instr_ready = 1'b1;
    redirect(10);
    tick();
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    check("coin_xfer3", 32'(xfer_pc[xfer_pc.size() - 1]), 32'd3);
    wait_valid(10, "coin_valid10");
    check("coin_next", 32'(instr_pc), 32'd10);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_valid", 32'(instr_valid), 32'd0);
    check("async_instr", 32'(instr), 32'd0);
    check("async_instr_pc", 32'(instr_pc), 32'd0);
    check("async_pc", 32'(pc), 32'd0);

    // Random ready and redirect traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      tick();
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) redirect(int'($urandom_range(0, DEPTH - 1)));
      else redirect_valid = 1'b0;
    end
    tick();
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    repeat (3) tick();
    check("rand_redir_drained", 32'(redir_q.size()), 32'd0);
    check("rand_progress", 32'(xfer_pc.size() > 50), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
